// File: rtl/turbo_pkg.sv
// ----------------------------------------------------------------------------
// turbo_pkg
// Shared constants for the turbo encoder input path:
//   - code-block sizes and QPP interleaver coefficients for the two lengths
//   - address width for the code-block buffers
//   - read-FSM state encoding of qpp_interleaver_buffer
//   - block_k(): maps the 1-bit length flag to the block size K
// ----------------------------------------------------------------------------
package turbo_pkg;

    localparam int K_SHORT  = 1056;
    localparam int K_LONG   = 6144;

    localparam int F1_SHORT = 17;
    localparam int F2_SHORT = 66;
    localparam int F1_LONG  = 263;
    localparam int F2_LONG  = 480;

    localparam int ADDR_W   = 13;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2,
        RD_GAPW   = 2'd3
    } rd_state_t;

    // Length flag 1 selects the long block, 0 the short one.
    function automatic logic [ADDR_W-1:0] block_k(input logic len);
        return len ? ADDR_W'(K_LONG) : ADDR_W'(K_SHORT);
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// ----------------------------------------------------------------------------
// qpp_addr_gen
// Generates the QPP interleaver address pi(i) = (f1*i + f2*i^2) mod K one
// index per step, using the second-order recursion
//   pi(i+1) = (pi(i) + g(i)) mod K,  g(i+1) = (g(i) + 2*f2) mod K
// so that only adders and a single conditional subtract are needed.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   start  : load pi(0)=0 and g(0)=(f1+f2) mod K for the given length
//   length : block size select sampled on start (1: K=6144, 0: K=1056)
//   step   : advance from pi(i) to pi(i+1)
//   pi     : current interleaved address
// ----------------------------------------------------------------------------
module qpp_addr_gen
    import turbo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              length,
    input  logic              step,
    output logic [ADDR_W-1:0] pi
);

    logic              len_q;
    logic [ADDR_W-1:0] g_q;

    logic [ADDR_W:0]   k_ext;
    logic [ADDR_W:0]   pi_sum;
    logic [ADDR_W:0]   pi_red;
    logic [ADDR_W:0]   g_sum;
    logic [ADDR_W:0]   g_red;
    logic [ADDR_W-1:0] two_f2;
    logic [ADDR_W-1:0] g_init;
    logic [ADDR_W-1:0] pi_next;
    logic [ADDR_W-1:0] g_next;

    // Both operands of each sum are already reduced below K, so the 14-bit
    // sum is below 2K and one conditional subtract completes the modulo.
    always_comb begin
        k_ext   = {1'b0, block_k(len_q)};
        two_f2  = len_q ? ADDR_W'(2 * F2_LONG) : ADDR_W'(2 * F2_SHORT);
        g_init  = length ? ADDR_W'(F1_LONG + F2_LONG) : ADDR_W'(F1_SHORT + F2_SHORT);

        pi_sum  = {1'b0, pi} + {1'b0, g_q};
        pi_red  = pi_sum - k_ext;
        pi_next = (pi_sum >= k_ext) ? pi_red[ADDR_W-1:0] : pi_sum[ADDR_W-1:0];

        g_sum   = {1'b0, g_q} + {1'b0, two_f2};
        g_red   = g_sum - k_ext;
        g_next  = (g_sum >= k_ext) ? g_red[ADDR_W-1:0] : g_sum[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= 1'b0;
            pi    <= '0;
            g_q   <= '0;
        end else if (start) begin
            len_q <= length;
            pi    <= '0;
            g_q   <= g_init;
        end else if (step) begin
            pi    <= pi_next;
            g_q   <= g_next;
        end
    end

endmodule

// File: rtl/qpp_interleaver_buffer.sv
// ----------------------------------------------------------------------------
// qpp_interleaver_buffer
// Collects serial systematic bits into two ping-pong code-block banks and
// streams each completed block to the turbo encoder as a natural-order bit
// (ck) and a QPP-interleaved bit (ckp) on the same cycle. A fixed idle gap
// after each block leaves the encoder room for trellis termination.
//
// Handshake: an input bit is transferred on every rising clk edge where
// in_valid and in_ready are both high; in_ready never depends on in_valid.
// The output side has no backpressure: data_valid marks K consecutive bits.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_bit     : serial systematic data bit
//   in_valid   : in_bit is valid
//   in_length  : block size select, sampled on the first bit of each block
//   in_ready   : the current write bank is free
//   data_valid : ck/ckp valid (to encoder data_valid)
//   ck         : natural-order bit c(i)
//   ckp        : interleaved bit c(pi(i))
//   length     : length flag of the block being streamed
// ----------------------------------------------------------------------------
module qpp_interleaver_buffer
    import turbo_pkg::*;
#(
    parameter int KMAX = 6144,
    parameter int GAP  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_length,
    output logic in_ready,
    output logic data_valid,
    output logic ck,
    output logic ckp,
    output logic length
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // Each bank is a pair of identically written RAMs so the natural and the
    // interleaved address can be read in the same cycle.
    logic nat_mem [2][KMAX];
    logic int_mem [2][KMAX];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wp;
    logic              wb;
    logic              cur_len;
    logic [1:0]        full;
    logic [1:0]        bank_len;

    logic              wr_en;
    logic              wr_len;
    logic [ADDR_W-1:0] wr_last_addr;
    logic              wr_last;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t         rd_state;
    logic              rb;
    logic [ADDR_W-1:0] rc;
    logic [ADDR_W-1:0] rd_k;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ADDR_W-1:0] pi_addr;

    logic              rd_start;
    logic              rd_step;
    logic              rd_fetch;
    logic              rd_done;

    assign in_ready = ~full[wb];

    always_comb begin
        wr_en        = in_valid & in_ready;
        // The first bit of a block uses the live length select; later bits
        // use the value captured with that first bit.
        wr_len       = (wp == '0) ? in_length : cur_len;
        wr_last_addr = block_k(wr_len) - ADDR_W'(1);
        wr_last      = wr_en && (wp == wr_last_addr);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            nat_mem[wb][wp] <= in_bit;
            int_mem[wb][wp] <= in_bit;
        end
    end

    // full[] is set by the write side and cleared by the read side. Both
    // never address the same bank in one cycle: the read side only clears
    // a bank that is full, and a full bank cannot be written.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            wb       <= 1'b0;
            cur_len  <= 1'b0;
            full     <= 2'b00;
            bank_len <= 2'b00;
        end else begin
            if (wr_en) begin
                if (wp == '0) begin
                    cur_len <= in_length;
                end
                if (wr_last) begin
                    full[wb]     <= 1'b1;
                    bank_len[wb] <= wr_len;
                    wb           <= ~wb;
                    wp           <= '0;
                end else begin
                    wp <= wp + ADDR_W'(1);
                end
            end
            if (rd_done) begin
                full[rb] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // rc is the next natural address to fetch. The RAM read lands directly
    // in the ck/ckp output registers, so the bit fetched at address rc is
    // visible one cycle later; PRIME fetches address 0 ahead of STREAM.
    // STREAM ends on the cycle where rc has reached K, i.e. while the bit
    // at K-1 is on the outputs.
    // ------------------------------------------------------------------
    always_comb begin
        rd_start = (rd_state == RD_IDLE) && full[rb];
        rd_step  = (rd_state == RD_PRIME) || (rd_state == RD_STREAM);
        rd_fetch = (rd_state == RD_PRIME) ||
                   ((rd_state == RD_STREAM) && (rc != rd_k));
        rd_done  = (rd_state == RD_STREAM) && (rc == rd_k);
    end

    qpp_addr_gen u_qpp_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .start  (rd_start),
        .length (bank_len[rb]),
        .step   (rd_step),
        .pi     (pi_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= RD_IDLE;
            rb         <= 1'b0;
            rc         <= '0;
            rd_k       <= '0;
            gap_cnt    <= '0;
            data_valid <= 1'b0;
            ck         <= 1'b0;
            ckp        <= 1'b0;
            length     <= 1'b0;
        end else begin
            if (rd_fetch) begin
                ck  <= nat_mem[rb][rc];
                ckp <= int_mem[rb][pi_addr];
                rc  <= rc + ADDR_W'(1);
            end

            case (rd_state)
                RD_IDLE: begin
                    if (full[rb]) begin
                        rd_k     <= block_k(bank_len[rb]);
                        rc       <= '0;
                        rd_state <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    data_valid <= 1'b1;
                    length     <= bank_len[rb];
                    rd_state   <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_done) begin
                        data_valid <= 1'b0;
                        rb         <= ~rb;
                        gap_cnt    <= '0;
                        rd_state   <= RD_GAPW;
                    end
                end
                RD_GAPW: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        rd_state <= RD_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpp_interleaver_buffer.sv
// ----------------------------------------------------------------------------
// tb_qpp_interleaver_buffer
// Self-checking bench for qpp_interleaver_buffer. Expected output streams
// come from a direct evaluation of pi(i) = (f1*i + f2*i^2) mod K on the
// stimulus data; timing expectations come from input acceptance cycles.
// ----------------------------------------------------------------------------
module tb_qpp_interleaver_buffer;

    localparam int GAP  = 4;
    localparam int KMAX = 6144;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    logic in_bit;
    logic in_valid;
    logic in_length;
    logic in_ready;
    logic data_valid;
    logic ck;
    logic ckp;
    logic length;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    qpp_interleaver_buffer #(
        .KMAX (KMAX),
        .GAP  (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_length  (in_length),
        .in_ready   (in_ready),
        .data_valid (data_valid),
        .ck         (ck),
        .ckp        (ckp),
        .length     (length)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] tx_q[$];       // {length, bit} per input bit
    logic       exp_ck_q[$];
    logic       exp_ckp_q[$];
    logic       exp_len_q[$];
    logic       obs_ck_q[$];
    logic       obs_ckp_q[$];
    logic       obs_len_q[$];
    int         acc_q[$];      // cycle each input bit was accepted
    int         rise_q[$];     // first data_valid cycle of each block
    int         fall_q[$];     // first data_valid-low cycle after each block
    int         rdy_fall_q[$];
    int         rdy_rise_q[$];
    int         last_acc_cyc;
    int         in_ones;
    bit         mon_en = 1'b0;
    logic       prev_dv;
    logic       prev_rdy;

    // ------------------------------------------------------------------
    // Reference model: closed-form QPP permutation
    // ------------------------------------------------------------------
    function automatic int qpp_pi(input logic len, input int i);
        longint k, f1, f2, li;
        k  = len ? 6144 : 1056;
        f1 = len ? 263 : 17;
        f2 = len ? 480 : 66;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_valid === 1'b1) begin
                obs_ck_q.push_back(ck);
                obs_ckp_q.push_back(ckp);
                obs_len_q.push_back(length);
            end
            if (data_valid === 1'b1 && prev_dv === 1'b0) rise_q.push_back(cyc);
            if (data_valid === 1'b0 && prev_dv === 1'b1) fall_q.push_back(cyc);
            if (in_ready === 1'b0 && prev_rdy === 1'b1) rdy_fall_q.push_back(cyc);
            if (in_ready === 1'b1 && prev_rdy === 1'b0) rdy_rise_q.push_back(cyc);
        end
        prev_dv  = data_valid;
        prev_rdy = in_ready;
    end

    task automatic clear_sb();
        tx_q.delete();
        exp_ck_q.delete();  exp_ckp_q.delete(); exp_len_q.delete();
        obs_ck_q.delete();  obs_ckp_q.delete(); obs_len_q.delete();
        acc_q.delete();     rise_q.delete();    fall_q.delete();
        rdy_fall_q.delete(); rdy_rise_q.delete();
        in_ones = 0;
    endtask

    // mode 0: single 1 at index pos; mode 1: random bits.
    task automatic queue_block(input logic len, input int mode, input int pos);
        int   k;
        logic d[];
        k = len ? 6144 : 1056;
        d = new[k];
        for (int i = 0; i < k; i++) begin
            d[i] = (mode == 0) ? (i == pos) : 1'($urandom_range(0, 1));
            if (d[i]) in_ones++;
        end
        for (int i = 0; i < k; i++) begin
            tx_q.push_back({len, d[i]});
            exp_ck_q.push_back(d[i]);
            exp_ckp_q.push_back(d[qpp_pi(len, i)]);
            exp_len_q.push_back(len);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: in_valid stays high until every queued bit is accepted.
    // ------------------------------------------------------------------
    task automatic send_all(input string name);
        int stall;
        stall = 0;
        while (tx_q.size() > 0 && stall < 20000) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_bit    = tx_q[0][0];
            in_length = tx_q[0][1];
            if (in_ready === 1'b1) begin
                acc_q.push_back(cyc);
                last_acc_cyc = cyc;
                void'(tx_q.pop_front());
            end else begin
                stall++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        tests_run++;
        if (tx_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL %s_send: %0d bits not accepted, required 0", name, tx_q.size());
            tx_q.delete();
        end
    endtask

    task automatic wait_blocks(input int n, input string name);
        int budget;
        budget = 20000;
        while (fall_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests_run++;
        if (fall_q.size() < n) begin
            tests_failed++;
            $display("FAIL %s_wait: %0d blocks streamed, required %0d", name, fall_q.size(), n);
        end
    endtask

    // Counts cycles where observed and expected streams disagree.
    function automatic int sb_diff(output int first);
        int bad, n, ne;
        bad   = 0;
        first = -1;
        n  = obs_ck_q.size();
        ne = exp_ck_q.size();
        for (int i = 0; i < ((n < ne) ? n : ne); i++) begin
            if (obs_ck_q[i] !== exp_ck_q[i] || obs_ckp_q[i] !== exp_ckp_q[i] ||
                obs_len_q[i] !== exp_len_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        bad += (n > ne) ? (n - ne) : (ne - n);
        return bad;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_length = 1'b0;
        repeat (4) @(negedge clk);
        tests_run += 5;
        if (in_ready !== 1'b1)   begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
        if (ck !== 1'b0)         begin tests_failed++; $display("FAIL reset_ck: got %b, required 0", ck); end
        if (ckp !== 1'b0)        begin tests_failed++; $display("FAIL reset_ckp: got %b, required 0", ckp); end
        if (length !== 1'b0)     begin tests_failed++; $display("FAIL reset_length: got %b, required 0", length); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run += 2;
        if (in_ready !== 1'b1)   begin tests_failed++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_data_valid: got %b, required 0", data_valid); end
        mon_en = 1'b1;
    endtask

    task automatic test_impulse(input logic len, input int pos, input int ckp_pos, input string name);
        int bad, first, ones_ck, pos_ck, ones_ckp, pos_ckp, k;
        k = len ? 6144 : 1056;
        clear_sb();
        queue_block(len, 0, pos);
        send_all(name);
        wait_blocks(1, name);
        bad = sb_diff(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL %s_stream: %0d bad cycles (first idx %0d), required 0", name, bad, first);
        end
        ones_ck = 0; pos_ck = -1; ones_ckp = 0; pos_ckp = -1;
        foreach (obs_ck_q[i])  if (obs_ck_q[i] === 1'b1)  begin ones_ck++;  pos_ck  = i; end
        foreach (obs_ckp_q[i]) if (obs_ckp_q[i] === 1'b1) begin ones_ckp++; pos_ckp = i; end
        tests_run += 2;
        if (ones_ck !== 1 || pos_ck !== pos) begin
            tests_failed++;
            $display("FAIL %s_ck_pos: %0d ones, last at %0d, required one at %0d", name, ones_ck, pos_ck, pos);
        end
        if (ones_ckp !== 1 || pos_ckp !== ckp_pos) begin
            tests_failed++;
            $display("FAIL %s_ckp_pos: %0d ones, last at %0d, required one at %0d", name, ones_ckp, pos_ckp, ckp_pos);
        end
        tests_run += 2;
        if (rise_q.size() < 1 || rise_q[0] - last_acc_cyc !== 3) begin
            tests_failed++;
            $display("FAIL %s_latency: first data_valid %0d cycles after last accept, required 3",
                     name, (rise_q.size() > 0) ? rise_q[0] - last_acc_cyc : -1);
        end
        if (rise_q.size() < 1 || fall_q.size() < 1 || fall_q[0] - rise_q[0] !== k) begin
            tests_failed++;
            $display("FAIL %s_run_len: got %0d cycles, required %0d", name,
                     (rise_q.size() > 0 && fall_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, k);
        end
    endtask

    task automatic test_permutation();
        int bad, first, ones_ckp;
        clear_sb();
        queue_block(1'b1, 1, 0);
        send_all("perm");
        wait_blocks(1, "perm");
        bad = sb_diff(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL perm_stream: %0d bad cycles (first idx %0d), required 0", bad, first);
        end
        ones_ckp = 0;
        foreach (obs_ckp_q[i]) if (obs_ckp_q[i] === 1'b1) ones_ckp++;
        tests_run++;
        if (ones_ckp !== in_ones || obs_ckp_q.size() !== 6144) begin
            tests_failed++;
            $display("FAIL perm_multiset: %0d ones in %0d ckp bits, required %0d in 6144",
                     ones_ckp, obs_ckp_q.size(), in_ones);
        end
    endtask

    task automatic test_back_to_back();
        int bad, first;
        clear_sb();
        for (int b = 0; b < 3; b++) queue_block(1'b0, 1, 0);
        send_all("b2b");
        wait_blocks(3, "b2b");
        bad = sb_diff(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL b2b_stream: %0d bad cycles (first idx %0d), required 0", bad, first);
        end
        tests_run += 4;
        if (rdy_fall_q.size() < 1 || acc_q.size() < 2112 || rdy_fall_q[0] !== acc_q[2111] + 1) begin
            tests_failed++;
            $display("FAIL b2b_ready_drop: dropped at cycle %0d, required %0d",
                     (rdy_fall_q.size() > 0) ? rdy_fall_q[0] : -1,
                     (acc_q.size() >= 2112) ? acc_q[2111] + 1 : -1);
        end
        if (rdy_rise_q.size() < 1 || fall_q.size() < 1 || rdy_rise_q[0] !== fall_q[0]) begin
            tests_failed++;
            $display("FAIL b2b_ready_rise: rose at cycle %0d, required %0d",
                     (rdy_rise_q.size() > 0) ? rdy_rise_q[0] : -1, (fall_q.size() > 0) ? fall_q[0] : -1);
        end
        if (rise_q.size() < 3 || fall_q.size() < 3 || rise_q[1] - fall_q[0] !== GAP + 2) begin
            tests_failed++;
            $display("FAIL b2b_gap01: got %0d low cycles, required %0d",
                     (rise_q.size() > 1) ? rise_q[1] - fall_q[0] : -1, GAP + 2);
        end
        if (rise_q.size() < 3 || fall_q.size() < 3 || rise_q[2] - fall_q[1] !== GAP + 2) begin
            tests_failed++;
            $display("FAIL b2b_gap12: got %0d low cycles, required %0d",
                     (rise_q.size() > 2) ? rise_q[2] - fall_q[1] : -1, GAP + 2);
        end
    endtask

    task automatic test_mixed();
        int bad, first;
        clear_sb();
        queue_block(1'b0, 1, 0);
        queue_block(1'b1, 1, 0);
        send_all("mixed");
        wait_blocks(2, "mixed");
        bad = sb_diff(first);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL mixed_stream: %0d bad cycles (first idx %0d), required 0", bad, first);
        end
        tests_run += 3;
        if (rise_q.size() < 2 || fall_q.size() < 2 || fall_q[0] - rise_q[0] !== 1056) begin
            tests_failed++;
            $display("FAIL mixed_run0: got %0d, required 1056",
                     (rise_q.size() > 0 && fall_q.size() > 0) ? fall_q[0] - rise_q[0] : -1);
        end
        if (rise_q.size() < 2 || fall_q.size() < 2 || fall_q[1] - rise_q[1] !== 6144) begin
            tests_failed++;
            $display("FAIL mixed_run1: got %0d, required 6144",
                     (rise_q.size() > 1 && fall_q.size() > 1) ? fall_q[1] - rise_q[1] : -1);
        end
        if (rise_q.size() < 2 || rise_q[1] - last_acc_cyc !== 3) begin
            tests_failed++;
            $display("FAIL mixed_latency1: got %0d, required 3",
                     (rise_q.size() > 1) ? rise_q[1] - last_acc_cyc : -1);
        end
    endtask

    task automatic test_reset_mid();
        int budget, target, rises, bad, first;
        clear_sb();
        queue_block(1'b0, 1, 0);
        send_all("rstmid");
        budget = 5000;
        while (rise_q.size() < 1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests_run++;
        if (rise_q.size() < 1) begin
            tests_failed++;
            $display("FAIL rstmid_start: no data_valid seen, required one block");
        end else begin
            target = rise_q[0] + 500;
            while (cyc < target) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            tests_run += 2;
            if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_data_valid: got %b, required 0", data_valid); end
            if (in_ready !== 1'b1)   begin tests_failed++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
            rst   = 1'b0;
            rises = rise_q.size();
            repeat (20) @(negedge clk);
            tests_run++;
            if (rise_q.size() !== rises) begin
                tests_failed++;
                $display("FAIL rstmid_discard: %0d blocks restarted, required 0", rise_q.size() - rises);
            end
        end
        clear_sb();
        queue_block(1'b0, 1, 0);
        send_all("rstnew");
        wait_blocks(1, "rstnew");
        bad = sb_diff(first);
        tests_run += 2;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL rstnew_stream: %0d bad cycles (first idx %0d), required 0", bad, first);
        end
        if (rise_q.size() < 1 || rise_q[0] - last_acc_cyc !== 3) begin
            tests_failed++;
            $display("FAIL rstnew_latency: got %0d, required 3",
                     (rise_q.size() > 0) ? rise_q[0] - last_acc_cyc : -1);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_impulse(1'b0, 83, 1, "imp1056");
        test_impulse(1'b1, 2446, 2, "imp6144");
        test_permutation();
        test_back_to_back();
        test_mixed();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qpp_interleaver_buffer.md
# qpp_interleaver_buffer

Upstream feeder for `turbo_encoder`. The block collects serial systematic bits into ping-pong code-block buffers. It then streams each completed block out as a natural-order bit `ck` and a QPP-interleaved bit `ckp` on the same cycle, with `data_valid` and `length` driven directly into the encoder. An idle gap between blocks gives the encoder room for its trellis-termination cycles.

## Interface
- `KMAX`, 6144: bank depth in bits; address width is 13.
- `GAP`, 4: minimum number of `data_valid`-low cycles between consecutive output blocks.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high; clock `clk`.
- `in_bit` input 1: serial systematic data bit.
- `in_valid` input 1: `in_bit` is valid; a bit is accepted when `in_valid & in_ready`.
- `in_length` input 1: block size select, sampled on the first accepted bit of each block. 1 selects K=6144; 0 selects K=1056.
- `in_ready` output 1: a write bank is available.
- `data_valid` output 1: `ck`/`ckp` are valid; connects to encoder `data_valid`.
- `ck` output 1: natural-order bit c(i).
- `ckp` output 1: interleaved bit c(pi(i)).
- `length` output 1: length flag of the block being streamed; held constant from the first to the last `data_valid` of the block.

## Operation
- Two banks, B0 and B1. Each bank is a pair of 1-bit×KMAX RAMs written identically: one is read at address i, the other at pi(i).
- Each bank has a full flag and a stored length bit.
- **Write side:**
  - The write pointer `wp` (13 bits) and write bank `wb` reset to 0.
  - Each accepted bit is written at address `wp`.
  - When `wp == K-1`: set `full[wb]`, latch the length into the bank, toggle `wb`, and clear `wp`.
  - `in_ready = ~full[wb]`.
- **QPP address generation**, with pi(i) = (f1·i + f2·i²) mod K:
  - K=1056 uses f1=17, f2=66. K=6144 uses f1=263, f2=480.
  - Recursion: pi(0)=0, g(0)=(f1+f2) mod K; pi(i+1)=(pi(i)+g(i)) mod K; g(i+1)=(g(i)+2·f2) mod K.
  - Each sum is formed at 14 bits and reduced by a single conditional subtract of K. No multipliers.
- **Read FSM:**
  - IDLE: if `full[rb]`, load the counter, pi, and g for that bank's K, then go to PRIME.
  - PRIME: 1 cycle for the RAM read latency. Go to STREAM.
  - STREAM: `data_valid=1` every cycle. The counter runs 0..K-1. At the last bit, clear `full[rb]`, toggle `rb`, and go to GAPW.
  - GAPW: `data_valid=0` for GAP cycles, then go to IDLE.
- **Simultaneous events:** a write-side set and a read-side clear of the same bank's full flag in one cycle cannot occur, because the banks differ. A clear of `full[wb]` in the same cycle makes `in_ready` high on the next cycle.
- **Reset mid-operation:** all flags, pointers, and the FSM return to the reset state; partial and buffered blocks are discarded. RAM contents are don't-care.

## Timing
- Reset values:
  - `in_ready`=1, `data_valid`=0, `ck`=0, `ckp`=0, `length`=0.
  - FSM=IDLE; `wb`=`rb`=0; `full`=00.
- Latency: with the read side in IDLE, the last input bit is accepted at cycle t, IDLE sees `full` at t+1, PRIME runs at t+2, and the first `data_valid` is at t+3.
- Output block: exactly K consecutive `data_valid` cycles, with no bubbles. There is no backpressure from the encoder.
- Inter-block: at least GAP idle cycles. Exactly GAP+2 idle cycles when the next bank is already full.
- Input throughput: 1 bit/cycle. `in_ready` deasserts the cycle after the second bank fills, while the first bank is still streaming.
- Outputs are registered; `ck`/`ckp`/`length` hold their last value when `data_valid`=0.

## Structure
- Package `turbo_pkg`:
  - `K_SHORT=1056`, `K_LONG=6144`.
  - `F1_SHORT=17`, `F2_SHORT=66`, `F1_LONG=263`, `F2_LONG=480`.
  - `ADDR_W=13`.
  - The read-FSM state enum.
- Sub-module `qpp_addr_gen`:
  - Inputs: `clk`, `rst`, `start`, `length`, `step`.
  - Output: `pi` (13 bits).
  - Contains the pi/g recursion registers.
- Top level holds the banks, write logic, and read FSM.

## Test plan
- 1056 impulse: a block with a 1 only at input index 83. Output shows `ck`=1 only at output index 83 and `ckp`=1 only at output index 1, since pi(1)=83. `length`=0 for all 1056 cycles.
- 6144 impulse: a 1 only at input index 2446. `ckp`=1 only at output index 2, since pi(2)=2446. `ck`=1 at index 2446. `length`=1.
- Permutation check: random 6144 block. The set of `ckp` values equals the input multiset, and each pi(i) matches a reference model for all i.
- Back-to-back: three 1056 blocks with `in_valid` held high.
  - `in_ready` drops after bit 2112.
  - `in_ready` rises again once block 0 finishes streaming.
  - Each block pair is separated by exactly GAP+2 low cycles of `data_valid`.
- Mixed lengths: a 1056 block followed by a 6144 block. `length` switches only between blocks, and the `data_valid` run lengths are 1056 then 6144.
- Reset mid-stream: assert `rst` at output index 500.
  - Next cycle: `data_valid`=0 and `in_ready`=1.
  - A fresh block afterwards streams correctly with latency 3.
